data_mem_ctrl: RTL and testbench

//  Parametrised, handshaked data memory for the CPU load/store stage. Little-endian, byte-addressed.

---
 rtl/data_mem_ctrl.sv | 135 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - handshaked byte-addressed data memory with wait states
// Define DMEM_MISALIGN_FAULT_EN to fault misaligned accesses instead of aligning them down.
module data_mem_ctrl #(
  parameter int    ADDR_W      = 14,
  parameter int    DATA_W      = 32,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_Req,
  input  logic              in_Write,
  input  logic [ADDR_W-1:0] in_Addr,
  input  logic [1:0]        in_Size,
  input  logic              in_Signed,
  input  logic [DATA_W-1:0] in_Wdata,
  output logic              out_Ready,
  output logic              out_Done,
  output logic [DATA_W-1:0] out_Rdata,
  output logic              out_Fault
);
  localparam int NL = DATA_W / 8;
  localparam int LB = $clog2(NL);
  localparam int IW = ADDR_W - LB;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_signed, r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] mem [2**IW];

  logic              idle, enter_resp, fault, illegal, misal, sign;
  logic [ADDR_W-1:0] e_addr, aligned;
  logic [1:0]        e_size;
  logic              e_signed, e_write;
  logic [DATA_W-1:0] e_wdata, wdata_sh, rd_sh, rd_ext;
  logic [LB-1:0]     off;
  logic [IW-1:0]     idx;
  logic [NL-1:0]     lane_en;
  int                nbytes, nbits, top;

  assign idle      = (state == S_IDLE);
  assign out_Ready = idle;
  assign out_Done  = (state == S_RESP);

  // With no wait states the access happens on the accept edge, so inputs are used directly.
  always_comb begin
    e_addr   = idle ? in_Addr   : r_addr;
    e_size   = idle ? in_Size   : r_size;
    e_signed = idle ? in_Signed : r_signed;
    e_write  = idle ? in_Write  : r_write;
    e_wdata  = idle ? in_Wdata  : r_wdata;
    enter_resp = !reset && ((idle && in_Req && WAIT_CYCLES == 0) ||
                            (state == S_WAIT && cnt == 4'd0));
    nbytes  = 1 << e_size;
    nbits   = nbytes * 8;
    illegal = (e_size == 2'b11) && (DATA_W == 32);
    case (e_size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = e_addr[0];
      2'b10:   misal = |e_addr[1:0];
      default: misal = |e_addr[2:0];
    endcase
    aligned = e_addr & ~((ADDR_W'(1) << e_size) - ADDR_W'(1));
`ifdef DMEM_MISALIGN_FAULT_EN
    fault = illegal | misal;
    off   = e_addr[LB-1:0];
`else
    fault = illegal;
    off   = aligned[LB-1:0];
`endif
    idx = e_addr[ADDR_W-1:LB];
    for (int i = 0; i < NL; i++)
      lane_en[i] = !fault && (i >= int'(off)) && (i < int'(off) + nbytes);
    wdata_sh = e_wdata << {off, 3'b000};
    rd_sh    = mem[idx] >> {off, 3'b000};
    top      = (nbits > DATA_W) ? DATA_W - 1 : nbits - 1;
    sign     = e_signed & rd_sh[top];
    for (int b = 0; b < DATA_W; b++)
      rd_ext[b] = (b < nbits) ? rd_sh[b] : sign;
  end

  always_ff @(posedge clock) begin
    if (enter_resp && e_write)
      for (int i = 0; i < NL; i++)
        if (lane_en[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      r_addr    <= '0;
      r_size    <= 2'b00;
      r_signed  <= 1'b0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      out_Rdata <= '0;
      out_Fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_Req) begin
          r_addr   <= in_Addr;
          r_size   <= in_Size;
          r_signed <= in_Signed;
          r_write  <= in_Write;
          r_wdata  <= in_Wdata;
          if (WAIT_CYCLES > 0) begin
            state <= S_WAIT;
            cnt   <= 4'(WAIT_CYCLES - 1);
          end else begin
            state <= S_RESP;
          end
        end
        S_WAIT: if (cnt == 4'd0) state <= S_RESP; else cnt <= cnt - 4'd1;
        S_RESP: begin
          state     <= S_IDLE;
          out_Fault <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
      if (enter_resp) begin
        out_Fault <= fault;
        if (fault) out_Rdata <= '0;
        else if (!e_write) out_Rdata <= rd_ext;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for data_mem_ctrl (32b/0ws, 32b/3ws, 64b/0ws)
module tb_data_mem_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        req[3], wr[3], sgn[3];
  logic [13:0] addr[3];
  logic [1:0]  size[3];
  logic [63:0] wd[3];
  logic        rdy[3], dn[3], flt[3];
  logic [31:0] rd0, rd1;
  logic [63:0] rd2;
  int          checks = 0;
  int          failures = 0;
  int          wcyc[3] = '{0, 3, 0};

  typedef struct {logic [63:0] rd; logic f; logic chk_rd;} exp_t;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  data_mem_ctrl #(.ADDR_W(14), .DATA_W(32), .WAIT_CYCLES(0)) u0 (
    .clock(clock), .reset(reset), .in_Req(req[0]), .in_Write(wr[0]), .in_Addr(addr[0]),
    .in_Size(size[0]), .in_Signed(sgn[0]), .in_Wdata(wd[0][31:0]), .out_Ready(rdy[0]),
    .out_Done(dn[0]), .out_Rdata(rd0), .out_Fault(flt[0]));
  data_mem_ctrl #(.ADDR_W(14), .DATA_W(32), .WAIT_CYCLES(3)) u1 (
    .clock(clock), .reset(reset), .in_Req(req[1]), .in_Write(wr[1]), .in_Addr(addr[1]),
    .in_Size(size[1]), .in_Signed(sgn[1]), .in_Wdata(wd[1][31:0]), .out_Ready(rdy[1]),
    .out_Done(dn[1]), .out_Rdata(rd1), .out_Fault(flt[1]));
  data_mem_ctrl #(.ADDR_W(14), .DATA_W(64), .WAIT_CYCLES(0)) u2 (
    .clock(clock), .reset(reset), .in_Req(req[2]), .in_Write(wr[2]), .in_Addr(addr[2]),
    .in_Size(size[2]), .in_Signed(sgn[2]), .in_Wdata(wd[2]), .out_Ready(rdy[2]),
    .out_Done(dn[2]), .out_Rdata(rd2), .out_Fault(flt[2]));

  function automatic logic [63:0] rdata(int d);
    case (d)
      0:       return {32'h0, rd0};
      1:       return {32'h0, rd1};
      default: return rd2;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(string tag, int d, logic w, logic [13:0] a, logic [1:0] s, logic sg,
                        logic [63:0] data, logic [63:0] exp_rd, logic exp_f, logic chk_rd);
    int   k;
    logic got;
    exp_t e;
    exp_q.push_back('{exp_rd, exp_f, chk_rd});
    @(negedge clock);
    req[d] = 1'b1; wr[d] = w; addr[d] = a; size[d] = s; sgn[d] = sg; wd[d] = data;
    @(posedge clock);
    #1;
    req[d] = 1'b0; addr[d] = 14'($urandom); wd[d] = {$urandom, $urandom}; sgn[d] = ~sg;
    k = 0; got = 1'b0;
    while (k < 20 && !got) begin
      @(negedge clock);
      k++;
      if (dn[d]) got = 1'b1;
      else chk({tag, "_ready_low"}, 64'(rdy[d]), 64'd0);
    end
    chk({tag, "_done"}, 64'(got), 64'd1);
    e = exp_q.pop_front();
    if (got) begin
      chk({tag, "_latency"}, 64'(k), 64'(wcyc[d] + 1));
      chk({tag, "_fault"}, 64'(flt[d]), 64'(e.f));
      if (e.chk_rd) chk({tag, "_rdata"}, rdata(d), e.rd);
      @(negedge clock);
      chk({tag, "_done_pulse"}, 64'(dn[d]), 64'd0);
      chk({tag, "_ready_back"}, 64'(rdy[d]), 64'd1);
      chk({tag, "_fault_clr"}, 64'(flt[d]), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i] = 0; wr[i] = 0; sgn[i] = 0; addr[i] = 0; size[i] = 0; wd[i] = 0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", 64'(rdy[i]), 64'd1);
      chk("rst_done", 64'(dn[i]), 64'd0);
      chk("rst_rdata", rdata(i), 64'd0);
      chk("rst_fault", 64'(flt[i]), 64'd0);
    end
    reset = 1'b0;

    access("st_word", 0, 1, 14'h10, 2'b10, 0, 64'hDEADBEEF, 0, 0, 0);
    access("ld_word", 0, 0, 14'h10, 2'b10, 0, 0, 64'hDEADBEEF, 0, 1);
    access("st_byte", 0, 1, 14'h13, 2'b00, 0, 64'h5A, 0, 0, 0);
    access("ld_word2", 0, 0, 14'h10, 2'b10, 0, 0, 64'h5AADBEEF, 0, 1);
    access("ld_b13_s", 0, 0, 14'h13, 2'b00, 1, 0, 64'h5A, 0, 1);
    access("st_b11", 0, 1, 14'h11, 2'b00, 0, 64'h80, 0, 0, 0);
    access("ld_b11_s", 0, 0, 14'h11, 2'b00, 1, 0, 64'hFFFFFF80, 0, 1);
    access("ld_b11_u", 0, 0, 14'h11, 2'b00, 0, 0, 64'h00000080, 0, 1);
    access("ld_word3", 0, 0, 14'h10, 2'b10, 0, 0, 64'h5AAD80EF, 0, 1);
    access("st_word2", 0, 1, 14'h10, 2'b10, 0, 64'h8001BEEF, 0, 0, 0);
    access("ld_h12_s", 0, 0, 14'h12, 2'b01, 1, 0, 64'hFFFF8001, 0, 1);
    access("ld_h12_u", 0, 0, 14'h12, 2'b01, 0, 0, 64'h00008001, 0, 1);
`ifdef DMEM_MISALIGN_FAULT_EN
    access("ld_h11_mis", 0, 0, 14'h11, 2'b01, 1, 0, 64'h0, 1, 1);
    access("st_h13_mis", 0, 1, 14'h13, 2'b01, 0, 64'h1234, 64'h0, 1, 1);
    access("ld_after_mis", 0, 0, 14'h10, 2'b10, 0, 0, 64'h8001BEEF, 0, 1);
`else
    access("ld_h11_align", 0, 0, 14'h11, 2'b01, 1, 0, 64'hFFFFBEEF, 0, 1);
    access("st_h13_align", 0, 1, 14'h13, 2'b01, 0, 64'h1234, 0, 0, 0);
    access("ld_after_align", 0, 0, 14'h10, 2'b10, 0, 0, 64'h1234BEEF, 0, 1);
`endif
    access("ld_size3_32", 0, 0, 14'h10, 2'b11, 0, 0, 64'h0, 1, 1);
    access("st_size3_32", 0, 1, 14'h10, 2'b11, 0, 64'hFFFFFFFF, 64'h0, 1, 1);
`ifdef DMEM_MISALIGN_FAULT_EN
    access("ld_after_sz3", 0, 0, 14'h10, 2'b10, 0, 0, 64'h8001BEEF, 0, 1);
`else
    access("ld_after_sz3", 0, 0, 14'h10, 2'b10, 0, 0, 64'h1234BEEF, 0, 1);
`endif

    access("w3_st", 1, 1, 14'h20, 2'b10, 0, 64'h11112222, 0, 0, 0);
    access("w3_ld", 1, 0, 14'h20, 2'b10, 0, 0, 64'h11112222, 0, 1);
    @(negedge clock);
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 14'h20; size[1] = 2'b10; wd[1] = 64'hFFFFFFFF;
    @(posedge clock);
    #1 req[1] = 1'b0;
    repeat (2) @(negedge clock);
    chk("w3_in_wait", 64'(rdy[1]), 64'd0);
    reset = 1'b1;
    #1;
    chk("w3_rst_ready", 64'(rdy[1]), 64'd1);
    chk("w3_rst_done", 64'(dn[1]), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("w3_no_done", 64'(dn[1]), 64'd0);
    end
    access("w3_ld_after_rst", 1, 0, 14'h20, 2'b10, 0, 0, 64'h11112222, 0, 1);

    access("d_st", 2, 1, 14'h08, 2'b11, 0, 64'h0123456789ABCDEF, 0, 0, 0);
    access("d_ld", 2, 0, 14'h08, 2'b11, 1, 0, 64'h0123456789ABCDEF, 0, 1);
    access("d_ld_w_hi", 2, 0, 14'h0C, 2'b10, 1, 0, 64'h0000000001234567, 0, 1);
    access("d_ld_w_lo_s", 2, 0, 14'h08, 2'b10, 1, 0, 64'hFFFFFFFF89ABCDEF, 0, 1);
    access("d_ld_w_lo_u", 2, 0, 14'h08, 2'b10, 0, 0, 64'h0000000089ABCDEF, 0, 1);
    access("d_ld_b_f", 2, 0, 14'h0F, 2'b00, 0, 0, 64'h01, 0, 1);
    access("d_ld_h_e", 2, 0, 14'h0E, 2'b01, 1, 0, 64'h0123, 0, 1);
    access("d_st_b_a", 2, 1, 14'h0A, 2'b00, 0, 64'h77, 0, 0, 0);
    access("d_ld2", 2, 0, 14'h08, 2'b11, 0, 0, 64'h012345678977CDEF, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
